trojan1: RTL and testbench
==========================

TROJAN1 -- requirements
Module: trojan1

Interface
REQ-001 Parameter PATTERN, default 4'b1011: r1 sequence to detect, bit 3 oldest sample, bit 0 newest.
REQ-002 Parameter THRESHOLD, default 4: pattern matches needed to fire; legal range 1..255.
REQ-003 Parameter HOLD_CYCLES, default 8: cycles trigger stays high per firing; legal range 1..255.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 r1  input  1  activity sample from the host, read on every rising clk edge.
REQ-007 trigger  output  1  registered payload-enable flag, driven directly from a flop.

Function
REQ-008 The block SHALL shift r1 into a 4-bit register on every edge in all states: shreg <= {shreg[2:0], r1}.
REQ-009 A fill counter SHALL count samples since reset or re-arm, saturating at 4; match = (fill == 4) && (shreg == PATTERN), decoded combinationally from registered values.
REQ-010 A 3-state FSM SHALL have states MONITOR, FIRE and COOLDOWN.
REQ-011 MONITOR: on an edge with match=1, match_cnt SHALL increment by 1; overlapping matches count individually.
REQ-012 MONITOR: if match=1 and match_cnt+1 == THRESHOLD, then at that edge: state<=FIRE, trigger<=1, hold_cnt<=0.
REQ-013 FIRE: hold_cnt SHALL increment each edge; at the edge where hold_cnt == HOLD_CYCLES-1: trigger<=0, state<=COOLDOWN, quiet_cnt<=0.
REQ-014 trigger SHALL be high for exactly HOLD_CYCLES consecutive cycles per firing.
REQ-015 FIRE and COOLDOWN: match_cnt SHALL be frozen and matches ignored.
REQ-016 COOLDOWN: quiet_cnt SHALL increment when r1=0 and clear when r1=1.
REQ-017 COOLDOWN exit: at the edge where r1=0 and quiet_cnt==1 (second consecutive low sample), state<=MONITOR, match_cnt<=0, fill<=0, shreg<=0.
REQ-018 match_cnt SHALL be 8 bits and never exceed THRESHOLD; no wrap-around is possible.
REQ-019 trigger SHALL be low in MONITOR and COOLDOWN.
REQ-020 No other state or payload SHALL exist; the block has no outputs besides trigger.

Reset
REQ-021 rst=1 SHALL immediately force: state=MONITOR, trigger=0, shreg=0, fill=0, match_cnt=0, hold_cnt=0, quiet_cnt=0.
REQ-022 Reset asserted mid-FIRE SHALL drop trigger asynchronously, without waiting for a clock edge.
REQ-023 Sampling SHALL resume on the first edge after rst deasserts; the 4-sample fill SHALL restart from 0.

Verification
REQ-024 Defaults; after reset drive r1 = 1,0,1,1 repeated four times (16 edges) -> matches become visible after edges 4, 8, 12 and 16; trigger rises at edge 17 and stays high 8 cycles (edges 17-24); falls at edge 25.
REQ-025 Defaults; drive r1 = 1,0,1,1,0,1,1 -> two overlapping matches, visible after edges 4 and 7; match_cnt=2 after edge 8; trigger stays 0.
REQ-026 After a firing, hold r1=1 in COOLDOWN -> no re-arm.
REQ-027 Continuing REQ-026, drive r1=0,0 -> MONITOR at the second low edge with match_cnt=0 and shreg=0.
REQ-028 Continuing REQ-027, three further 1011 groups -> trigger stays 0.
REQ-029 Assert rst during FIRE cycle 3 -> trigger=0 immediately.
REQ-030 Continuing REQ-029, after release drive 1,0,1 then 1 -> no match before fill reaches 4; the first match becomes visible after the 4th post-reset edge.
REQ-031 THRESHOLD=1, HOLD_CYCLES=1; drive 1,0,1,1,0 -> trigger high for exactly one cycle, on the edge after the first match becomes visible.
REQ-032 Drive r1=1 constantly, or never match PATTERN, for 1000 cycles -> trigger stays 0 and match_cnt stays 0.

Source files
------------

// File: rtl/trojan1.sv
// -----------------------------------------------------------------------------
// trojan1 -- sequence-triggered payload-enable flag.
//
// The host activity sample r1 is shifted into a 4-bit window on every clock.
// Once the window holds four real samples and equals PATTERN, a match is
// flagged. After THRESHOLD matches (overlaps count individually) trigger is
// raised for exactly HOLD_CYCLES cycles. The block then waits in a cooldown
// state until r1 has been low on two consecutive edges, and then re-arms with
// a clean window and a zero match count.
//
// Ports
//   clk      in  1  rising-edge clock for all state
//   rst      in  1  asynchronous, active-high reset
//   r1       in  1  activity sample, read on every rising clk edge
//   trigger  out 1  registered payload-enable flag (driven straight from a flop)
//
// Parameters
//   PATTERN      4-bit sequence to detect, bit 3 oldest sample, bit 0 newest
//   THRESHOLD    matches needed to fire, 1..255
//   HOLD_CYCLES  cycles trigger stays high per firing, 1..255
// -----------------------------------------------------------------------------
module trojan1 #(
  parameter logic [3:0] PATTERN     = 4'b1011,
  parameter int         THRESHOLD   = 4,
  parameter int         HOLD_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic r1,
  output logic trigger
);

  // Explicit encodings keep the state register easy to probe from a checker.
  typedef enum logic [1:0] {
    MONITOR  = 2'd0,
    FIRE     = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  localparam logic [8:0] THR_LIMIT = 9'(THRESHOLD);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e     state_q,     state_d;
  logic       trigger_q,   trigger_d;
  logic [3:0] shreg_q,     shreg_d;
  logic [2:0] fill_q,      fill_d;
  logic [7:0] match_cnt_q, match_cnt_d;
  logic [7:0] hold_cnt_q,  hold_cnt_d;
  logic [1:0] quiet_cnt_q, quiet_cnt_d;

  logic       match;
  logic [8:0] match_cnt_inc;

  // A match needs a full window: samples from before reset or re-arm never
  // take part, so the comparison is gated by the saturated fill counter.
  assign match = (fill_q == 3'd4) && (shreg_q == PATTERN);

  // Widened by one bit so the threshold compare cannot be fooled by a wrap.
  assign match_cnt_inc = {1'b0, match_cnt_q} + 9'd1;

  assign trigger = trigger_q;

  // ---------------------------------------------------------------------------
  // Next-state and datapath decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    trigger_d   = trigger_q;
    shreg_d     = {shreg_q[2:0], r1};
    fill_d      = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
    match_cnt_d = match_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    quiet_cnt_d = quiet_cnt_q;

    unique case (state_q)
      MONITOR: begin
        trigger_d = 1'b0;
        if (match) begin
          match_cnt_d = match_cnt_inc[7:0];
          if (match_cnt_inc == THR_LIMIT) begin
            state_d    = FIRE;
            trigger_d  = 1'b1;
            hold_cnt_d = 8'd0;
          end
        end
      end

      FIRE: begin
        // hold_cnt counts the cycles trigger has already been high; the edge
        // that sees the last count ends the pulse, giving HOLD_CYCLES cycles.
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d     = COOLDOWN;
          trigger_d   = 1'b0;
          quiet_cnt_d = 2'd0;
        end
      end

      COOLDOWN: begin
        trigger_d = 1'b0;
        if (r1) begin
          quiet_cnt_d = 2'd0;
        end else if (quiet_cnt_q == 2'd1) begin
          // Second consecutive low sample: re-arm with a clean slate. The
          // window is cleared rather than shifted so no stale bits survive.
          state_d     = MONITOR;
          match_cnt_d = 8'd0;
          fill_d      = 3'd0;
          shreg_d     = 4'd0;
          quiet_cnt_d = 2'd0;
        end else begin
          quiet_cnt_d = quiet_cnt_q + 2'd1;
        end
      end

      default: begin
        state_d   = MONITOR;
        trigger_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers; reset is asynchronous so trigger drops immediately.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MONITOR;
      trigger_q   <= 1'b0;
      shreg_q     <= 4'd0;
      fill_q      <= 3'd0;
      match_cnt_q <= 8'd0;
      hold_cnt_q  <= 8'd0;
      quiet_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      trigger_q   <= trigger_d;
      shreg_q     <= shreg_d;
      fill_q      <= fill_d;
      match_cnt_q <= match_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
    end
  end

endmodule

// File: tb/tb_trojan1.sv
// -----------------------------------------------------------------------------
// tb_trojan1 -- directed self-checking bench for trojan1.
//
// Two instances share clk, rst and r1: dut uses the default parameters,
// dut_t1 uses THRESHOLD=1, HOLD_CYCLES=1. r1 is driven with blocking
// assignments; outputs are sampled 1 time unit after each rising edge.
// Internal registers are probed hierarchically as observed values only.
// -----------------------------------------------------------------------------
module tb_trojan1;

  localparam logic [1:0] ST_MONITOR  = 2'd0;
  localparam logic [1:0] ST_FIRE     = 2'd1;
  localparam logic [1:0] ST_COOLDOWN = 2'd2;

  logic clk;
  logic rst;
  logic r1;
  logic trigger;
  logic trigger_t1;

  int n_checks;
  int n_errors;

  logic [3:0] pat;

  trojan1 dut (
    .clk     (clk),
    .rst     (rst),
    .r1      (r1),
    .trigger (trigger)
  );

  trojan1 #(
    .PATTERN     (4'b1011),
    .THRESHOLD   (1),
    .HOLD_CYCLES (1)
  ) dut_t1 (
    .clk     (clk),
    .rst     (rst),
    .r1      (r1),
    .trigger (trigger_t1)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  // One clock edge with the given sample; returns 1 unit after the edge.
  task automatic step(input logic v);
    r1 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    r1  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    pat      = 4'b1011;
    rst      = 1'b1;
    r1       = 1'b0;

    // Reset state
    #12;
    check("rst_trigger",   32'(trigger),          32'd0);
    check("rst_state",     32'(dut.state_q),      32'(ST_MONITOR));
    check("rst_match_cnt", 32'(dut.match_cnt_q),  32'd0);
    check("rst_shreg",     32'(dut.shreg_q),      32'd0);
    check("rst_fill",      32'(dut.fill_q),       32'd0);
    do_reset();

    // Four 1011 groups: matches after edges 4, 8, 12, 16; fire at edge 17.
    for (int e = 1; e <= 16; e++) begin
      step(pat[3 - ((e - 1) % 4)]);
      check("a_trig_low", 32'(trigger), 32'd0);
      check("a_match", 32'(dut.match), (e % 4 == 0) ? 32'd1 : 32'd0);
    end
    check("a_cnt_e16", 32'(dut.match_cnt_q), 32'd3);
    // r1 held high from here on so cooldown cannot exit.
    for (int e = 17; e <= 24; e++) begin
      step(1'b1);
      check("a_trig_high", 32'(trigger), 32'd1);
    end
    check("a_cnt_frozen", 32'(dut.match_cnt_q), 32'd4);
    step(1'b1);
    check("a_trig_fall", 32'(trigger), 32'd0);
    check("a_state_cool", 32'(dut.state_q), 32'(ST_COOLDOWN));

    // Cooldown with r1 high: no re-arm.
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      check("cool_hold", 32'(dut.state_q), 32'(ST_COOLDOWN));
      check("cool_trig", 32'(trigger), 32'd0);
    end
    // A single low sample followed by a high one does not re-arm.
    step(1'b0);
    check("cool_one_low", 32'(dut.state_q), 32'(ST_COOLDOWN));
    step(1'b1);
    check("cool_cleared", 32'(dut.state_q), 32'(ST_COOLDOWN));
    // Two consecutive lows re-arm.
    step(1'b0);
    check("rearm_first_low", 32'(dut.state_q), 32'(ST_COOLDOWN));
    step(1'b0);
    check("rearm_state", 32'(dut.state_q),     32'(ST_MONITOR));
    check("rearm_cnt",   32'(dut.match_cnt_q), 32'd0);
    check("rearm_shreg", 32'(dut.shreg_q),     32'd0);
    check("rearm_fill",  32'(dut.fill_q),      32'd0);

    // Three more 1011 groups: only two matches counted, no firing.
    for (int e = 1; e <= 12; e++) begin
      step(pat[3 - ((e - 1) % 4)]);
      check("b_trig_low", 32'(trigger), 32'd0);
    end
    check("b_cnt", 32'(dut.match_cnt_q), 32'd2);
    check("b_match_vis", 32'(dut.match), 32'd1);

    // Overlapping matches: 1,0,1,1,0,1,1 then one more edge.
    do_reset();
    step(1'b1); step(1'b0); step(1'b1);
    check("ov_no_match_e3", 32'(dut.match), 32'd0);
    step(1'b1);
    check("ov_match_e4", 32'(dut.match), 32'd1);
    step(1'b0);
    check("ov_match_e5", 32'(dut.match), 32'd0);
    check("ov_cnt_e5", 32'(dut.match_cnt_q), 32'd1);
    step(1'b1);
    step(1'b1);
    check("ov_match_e7", 32'(dut.match), 32'd1);
    step(1'b0);
    check("ov_cnt_e8", 32'(dut.match_cnt_q), 32'd2);
    check("ov_trig", 32'(trigger), 32'd0);

    // Reset during the third FIRE cycle drops trigger without a clock edge.
    do_reset();
    for (int e = 1; e <= 16; e++) step(pat[3 - ((e - 1) % 4)]);
    step(1'b0); step(1'b0); step(1'b0);
    check("fire_c3_trig", 32'(trigger), 32'd1);
    check("fire_c3_state", 32'(dut.state_q), 32'(ST_FIRE));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_trig",  32'(trigger),         32'd0);
    check("async_rst_state", 32'(dut.state_q),     32'(ST_MONITOR));
    check("async_rst_hold",  32'(dut.hold_cnt_q),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Post-reset fill: 1,0,1 never matches, the fourth sample does.
    step(1'b1);
    check("fill1_match", 32'(dut.match), 32'd0);
    check("fill1", 32'(dut.fill_q), 32'd1);
    step(1'b0);
    check("fill2_match", 32'(dut.match), 32'd0);
    step(1'b1);
    check("fill3_match", 32'(dut.match), 32'd0);
    check("fill3", 32'(dut.fill_q), 32'd3);
    step(1'b1);
    check("fill4_match", 32'(dut.match), 32'd1);
    check("fill4", 32'(dut.fill_q), 32'd4);

    // THRESHOLD=1, HOLD_CYCLES=1: one-cycle pulse after the first match.
    do_reset();
    step(1'b1); step(1'b0); step(1'b1); step(1'b1);
    check("t1_e4_trig", 32'(trigger_t1), 32'd0);
    check("t1_e4_match", 32'(dut_t1.match), 32'd1);
    step(1'b0);
    check("t1_e5_trig", 32'(trigger_t1), 32'd1);
    step(1'b0);
    check("t1_e6_trig", 32'(trigger_t1), 32'd0);
    check("t1_e6_state", 32'(dut_t1.state_q), 32'(ST_COOLDOWN));
    step(1'b0);
    check("t1_e7_trig", 32'(trigger_t1), 32'd0);

    // Long idle: constant high, then a non-matching 1100 loop.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      step(1'b1);
      check("idle_high_trig", 32'(trigger), 32'd0);
    end
    check("idle_high_cnt", 32'(dut.match_cnt_q), 32'd0);
    for (int i = 0; i < 1000; i++) begin
      step((i % 4) < 2);
      check("idle_1100_trig", 32'(trigger), 32'd0);
    end
    check("idle_1100_cnt", 32'(dut.match_cnt_q), 32'd0);
    check("idle_state", 32'(dut.state_q), 32'(ST_MONITOR));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit in case a wait goes astray.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
